// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants and encodings for the data-RAM port arbiter, its burst
// counter and the memory stages that share the 128x32 data RAM.
package dmem_port_arbiter_pkg;

  localparam int DMEM_ADDR_W   = 7;
  localparam int DMEM_DATA_W   = 32;
  localparam int DMEM_MAX_WAIT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_e;

  typedef enum logic {
    OWN_PIPE = 1'b0,
    OWN_LDR  = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_burst_ctr.sv
// Loader burst sequencer: latches base/length/direction on start, walks a
// wrapping word address per accepted beat and pulses done after the last beat.
module dmem_burst_ctr
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [7:0]        len_i,
  input  logic              beat_i,
  output logic              busy_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              done_o
);

  burst_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              done_q, done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = base_i;
          cnt_d   = len_i;
          we_d    = we_i;
          state_d = BURST;
        end
      end
      BURST: begin
        if (beat_i) begin
          // Address wraps naturally at the top of the RAM.
          addr_d = addr_q + ADDR_W'(1);
          if (cnt_q == 8'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == BURST);
  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign done_o = done_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-RAM port arbiter: pipeline has priority, a starvation counter forces a
// loader grant, read data is steered by a 1-bit owner tag. Option: DMEM_ARB_PERF_EN.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
  input  logic              clock,
  input  logic              reset,
`ifdef DMEM_ARB_PERF_EN
  output logic [15:0]       perf_stall_cnt,
  output logic [7:0]        perf_force_cnt,
`endif
  input  logic              p_req,
  input  logic              p_we,
  input  logic [31:0]       p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              l_start,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_base,
  input  logic [7:0]        l_len,
  input  logic              l_valid,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ready,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_busy,
  output logic              l_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wre,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic              busy, ldr_we, ldr_contend, forced, l_gnt;
  logic [ADDR_W-1:0] ldr_addr, p_word, addr_q;
  logic [3:0]        wait_q, wait_d;
  logic              rd_vld_q, rd_vld_d;
  owner_e            rd_own_q, rd_own_d;
  logic [DATA_W-1:0] p_rdata_q, l_rdata_q;
  logic              unused_addr_bits;

  assign p_word           = p_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{p_addr[31:ADDR_W+2], p_addr[1:0]};
  assign l_busy           = busy;

  dmem_burst_ctr #(.ADDR_W(ADDR_W)) u_burst (
    .clock   (clock),
    .reset   (reset),
    .start_i (l_start & ~busy),
    .we_i    (l_we),
    .base_i  (l_base),
    .len_i   (l_len),
    .beat_i  (l_gnt),
    .busy_o  (busy),
    .we_o    (ldr_we),
    .addr_o  (ldr_addr),
    .done_o  (l_done)
  );

  always_comb begin
    ldr_contend = busy & l_valid;
    forced      = ldr_contend & (wait_q == WAIT_MAX);
    l_gnt       = ldr_contend & (~p_req | forced);
    p_gnt       = p_req & ~l_gnt;
    p_stall     = p_req & ~p_gnt;
    l_ready     = l_gnt;

    wait_d = wait_q;
    if (!ldr_contend || l_gnt)  wait_d = '0;
    else if (wait_q != WAIT_MAX) wait_d = wait_q + 4'd1;

    // Idle cycles keep the last address on the RAM bus.
    ram_addr  = addr_q;
    ram_wdata = '0;
    ram_wre   = 1'b0;
    rd_vld_d  = 1'b0;
    rd_own_d  = rd_own_q;
    if (l_gnt) begin
      ram_addr  = ldr_addr;
      ram_wdata = l_wdata;
      ram_wre   = ldr_we;
      rd_vld_d  = ~ldr_we;
      rd_own_d  = OWN_LDR;
    end else if (p_gnt) begin
      ram_addr  = p_word;
      ram_wdata = p_wdata;
      ram_wre   = p_we;
      rd_vld_d  = ~p_we;
      rd_own_d  = OWN_PIPE;
    end

    p_rvalid = rd_vld_q & (rd_own_q == OWN_PIPE);
    l_rvalid = rd_vld_q & (rd_own_q == OWN_LDR);
    p_rdata  = p_rvalid ? ram_rdata : p_rdata_q;
    l_rdata  = l_rvalid ? ram_rdata : l_rdata_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_q    <= '0;
      addr_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_own_q  <= OWN_PIPE;
      p_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      wait_q    <= wait_d;
      addr_q    <= ram_addr;
      rd_vld_q  <= rd_vld_d;
      rd_own_q  <= rd_own_d;
      p_rdata_q <= p_rdata;
      l_rdata_q <= l_rdata;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perf_stall_q;
  logic [7:0]  perf_force_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_force_q <= '0;
    end else begin
      if (p_stall && perf_stall_q != 16'hFFFF) perf_stall_q <= perf_stall_q + 16'd1;
      if (forced && perf_force_q != 8'hFF)     perf_force_q <= perf_force_q + 8'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_force_cnt = perf_force_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios then random traffic checked
// against a transaction-level model of the shared RAM and loader burst.
module tb_dmem_port_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          p_req, p_we;
  logic [31:0]   p_addr;
  logic [DW-1:0] p_wdata;
  logic          p_gnt, p_stall, p_rvalid;
  logic [DW-1:0] p_rdata;
  logic          l_start, l_we, l_valid;
  logic [AW-1:0] l_base;
  logic [7:0]    l_len;
  logic [DW-1:0] l_wdata;
  logic          l_ready, l_rvalid, l_busy, l_done;
  logic [DW-1:0] l_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_wre;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0]   perf_stall_cnt;
  logic [7:0]    perf_force_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [DW-1:0] ram [128] = '{default: '0};
  logic [DW-1:0] mem_ref [128] = '{default: '0};

  bit            m_busy, m_we, m_done, m_rd_pend, m_rd_ldr;
  int            m_addr, m_left, m_streak, m_last_addr;
  logic [DW-1:0] m_rd_data, m_prdata, m_ldata;

  dmem_port_arbiter dut (
    .clock(clock), .reset(reset),
`ifdef DMEM_ARB_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_force_cnt(perf_force_cnt),
`endif
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .l_start(l_start), .l_we(l_we), .l_base(l_base), .l_len(l_len),
    .l_valid(l_valid), .l_wdata(l_wdata), .l_ready(l_ready), .l_rvalid(l_rvalid),
    .l_rdata(l_rdata), .l_busy(l_busy), .l_done(l_done),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wre(ram_wre), .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wre) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    l_start = 0; l_we = 0; l_base = '0; l_len = '0; l_valid = 0; l_wdata = '0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_we = 0; m_done = 0; m_rd_pend = 0; m_rd_ldr = 0;
    m_addr = 0; m_left = 0; m_streak = 0; m_last_addr = 0;
    m_rd_data = '0; m_prdata = '0; m_ldata = '0;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs();
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    model_reset();
  endtask

  // One clock: compare all outputs against the model, then advance the model.
  task automatic cycle();
    bit lc, lg, pg, was_busy;
    int pw;
    logic [DW-1:0] exp_p, exp_l;
    #1;
    lc = m_busy && l_valid;
    lg = lc && (!p_req || m_streak == MW);
    pg = p_req && !lg;
    pw = int'(p_addr[8:2]);
    exp_p = (m_rd_pend && !m_rd_ldr) ? m_rd_data : m_prdata;
    exp_l = (m_rd_pend && m_rd_ldr) ? m_rd_data : m_ldata;
    chk("p_gnt", p_gnt, pg);
    chk("l_ready", l_ready, lg);
    chk("p_stall", p_stall, p_req && !pg);
    chk("l_busy", l_busy, m_busy);
    chk("l_done", l_done, m_done);
    chk("p_rvalid", p_rvalid, m_rd_pend && !m_rd_ldr);
    chk("l_rvalid", l_rvalid, m_rd_pend && m_rd_ldr);
    chk("p_rdata", p_rdata, exp_p);
    chk("l_rdata", l_rdata, exp_l);
    chk("ram_addr", ram_addr, lg ? m_addr : (pg ? pw : m_last_addr));
    chk("ram_wre", ram_wre, lg ? m_we : (pg ? p_we : 1'b0));
    chk("ram_wdata", ram_wdata, lg ? l_wdata : (pg ? p_wdata : '0));

    m_prdata = exp_p;
    m_ldata  = exp_l;
    m_rd_pend = 0;
    m_done = 0;
    was_busy = m_busy;
    if (lg) begin
      if (m_we) mem_ref[m_addr] = l_wdata;
      else begin m_rd_pend = 1; m_rd_ldr = 1; m_rd_data = mem_ref[m_addr]; end
      m_last_addr = m_addr;
      if (m_left == 0) begin m_busy = 0; m_done = 1; end
      else m_left--;
      m_addr = (m_addr + 1) % 128;
    end else if (pg) begin
      if (p_we) mem_ref[pw] = p_wdata;
      else begin m_rd_pend = 1; m_rd_ldr = 0; m_rd_data = mem_ref[pw]; end
      m_last_addr = pw;
    end
    if (lc && !lg) m_streak = (m_streak < MW) ? m_streak + 1 : MW;
    else m_streak = 0;
    if (!was_busy && l_start) begin
      m_busy = 1; m_addr = int'(l_base); m_left = int'(l_len); m_we = l_we;
    end
    @(negedge clock);
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_busy", l_busy, 1'b0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_prdata", p_rdata, 0);
    cycle();

    // Preload words 4, 2 and 9 through pipeline writes.
    p_req = 1; p_we = 1; p_addr = 32'h10; p_wdata = 32'hDEADBEEF; cycle();
    p_addr = 32'h08; p_wdata = 32'h2222_2222; cycle();
    p_addr = 32'h24; p_wdata = 32'h9999_9999; cycle();

    // Pipeline-only read of word 4.
    p_we = 0; p_addr = 32'h0000_0010;
    #1;
    chk("t1_gnt", p_gnt, 1'b1);
    chk("t1_addr", ram_addr, 4);
    cycle();
    idle_inputs();
    #1;
    chk("t1_rvalid", p_rvalid, 1'b1);
    chk("t1_rdata", p_rdata, 32'hDEADBEEF);
    cycle();

    // Uncontended write burst wrapping 126,127,0,1.
    l_start = 1; l_we = 1; l_base = 7'd126; l_len = 8'd3; cycle();
    l_start = 0; l_valid = 1;
    for (int i = 0; i < 4; i++) begin
      l_wdata = 32'hA000_0000 + i;
      #1;
      chk("t2_ready", l_ready, 1'b1);
      chk("t2_addr", ram_addr, (126 + i) % 128);
      cycle();
    end
    l_valid = 0;
    #1;
    chk("t2_done", l_done, 1'b1);
    chk("t2_busy", l_busy, 1'b0);
    cycle();
    p_req = 1; p_addr = 32'h0; cycle();
    p_req = 0;
    #1;
    chk("t2_wrap_data", p_rdata, 32'hA000_0002);
    cycle();

    // Starvation: forced loader grant every 5th contending cycle.
    do_reset();
    l_start = 1; l_we = 1; l_base = 7'd20; l_len = 8'd30; cycle();
    l_start = 0; p_req = 1; p_we = 0; p_addr = 32'h40; l_valid = 1;
    for (int k = 1; k <= 20; k++) begin
      l_wdata = 32'h5500_0000 + k;
      #1;
      chk("t3_ready", l_ready, (k % 5) == 0);
      chk("t3_stall", p_stall, (k % 5) == 0);
      cycle();
    end
    p_req = 0; l_valid = 0;
`ifdef DMEM_ARB_PERF_EN
    #1;
    chk("t6_force_cnt", perf_force_cnt, 4);
    chk("t6_stall_cnt", perf_stall_cnt, 4);
`endif
    cycle();

    // Interleaved reads: pipe reads word 2 then forced loader reads word 9.
    do_reset();
    l_start = 1; l_we = 0; l_base = 7'd9; l_len = 8'd0; cycle();
    l_start = 0; p_req = 1; p_we = 0; p_addr = 32'h08; l_valid = 1;
    for (int k = 0; k < 4; k++) cycle();
    #1;
    chk("t4_lready", l_ready, 1'b1);
    chk("t4_prvalid", p_rvalid, 1'b1);
    chk("t4_prdata", p_rdata, 32'h2222_2222);
    chk("t4_lrvalid_early", l_rvalid, 1'b0);
    cycle();
    p_req = 0; l_valid = 0;
    #1;
    chk("t4_lrvalid", l_rvalid, 1'b1);
    chk("t4_lrdata", l_rdata, 32'h9999_9999);
    chk("t4_prvalid_late", p_rvalid, 1'b0);
    cycle();

    // Reset in the middle of an 8-beat burst.
    do_reset();
    l_start = 1; l_we = 1; l_base = 7'd50; l_len = 8'd7; cycle();
    l_start = 0; l_valid = 1; l_wdata = 32'h7777_0001; cycle();
    l_wdata = 32'h7777_0002; cycle();
    reset = 1; idle_inputs();
    @(negedge clock);
    reset = 0;
    model_reset();
    #1;
    chk("t5_busy", l_busy, 1'b0);
    chk("t5_done", l_done, 1'b0);
    chk("t5_ready", l_ready, 1'b0);
    chk("t5_rvalid", l_rvalid, 1'b0);
    chk("t5_ram_addr", ram_addr, 0);
    chk("t5_ram_wre", ram_wre, 1'b0);
    cycle();
    l_start = 1; l_we = 1; l_base = 7'd5; l_len = 8'd1; cycle();
    l_start = 0;
    #1;
    chk("t5_restart_busy", l_busy, 1'b1);
    l_valid = 1;
    for (int k = 0; k < 3; k++) cycle();
    l_valid = 0;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      p_req   = ($urandom_range(0, 3) != 0);
      p_we    = $urandom_range(0, 1) == 1;
      p_addr  = $urandom;
      p_wdata = $urandom;
      l_start = ($urandom_range(0, 3) == 0);
      l_we    = $urandom_range(0, 1) == 1;
      l_base  = AW'($urandom_range(0, 127));
      l_len   = 8'($urandom_range(0, 12));
      l_valid = ($urandom_range(0, 4) != 0);
      l_wdata = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
